// File: rtl/preg_release_unit_pkg.sv
// -----------------------------------------------------------------------------
// preg_release_unit_pkg
// Shared types and constants for the commit-side physical register release
// unit: physical/architectural register index types and the arch RAT entry.
// COMMIT_WIDTH (commit lanes per cycle) defaults to 4 when the build does not
// define it.
// -----------------------------------------------------------------------------
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

package preg_release_unit_pkg;

    localparam int PHY_REG_NUM_DEF  = 64;
    localparam int ARCH_REG_NUM_DEF = 32;
    localparam int PREG_W           = $clog2(PHY_REG_NUM_DEF);
    localparam int AREG_W           = $clog2(ARCH_REG_NUM_DEF);

    typedef logic [PREG_W-1:0] preg_t;
    typedef logic [AREG_W-1:0] areg_t;

    typedef struct packed {
        logic  valid;
        preg_t preg;
    } rat_entry_t;

endpackage

// File: rtl/preg_release_unit_release_fifo.sv
// -----------------------------------------------------------------------------
// release_fifo
// Multi-push / multi-pop circular FIFO. Up to LANES entries are pushed per
// cycle (already compacted from lane 0); the oldest min(occupancy, LANES)
// entries are always presented and all of them pop together on pop_i.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   push_data_i     compacted entries, lane 0 first
//   push_cnt_i      number of valid entries in push_data_i
//   pop_i           pop every presented entry
//   head_data_o     oldest entries (lane 0 = oldest)
//   head_cnt_o      number of presented entries
//   occ_o           current occupancy
// -----------------------------------------------------------------------------
module release_fifo #(
    parameter int DEPTH = 8,
    parameter int LANES = 4,
    parameter int DW    = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [LANES-1:0][DW-1:0]            push_data_i,
    input  logic [$clog2(LANES+1)-1:0]          push_cnt_i,
    input  logic                                pop_i,
    output logic [LANES-1:0][DW-1:0]            head_data_o,
    output logic [$clog2(LANES+1)-1:0]          head_cnt_o,
    output logic [$clog2(DEPTH+1)-1:0]          occ_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int NW    = $clog2(LANES+1);
    localparam int OW    = $clog2(DEPTH+1);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [NW-1:0]    pop_cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        always_ff @(posedge clk) begin
            if (NW'(gi) < push_cnt_i) begin
                mem_q[wr_ptr_q + PTR_W'(gi)] <= push_data_i[gi];
            end
        end
        assign head_data_o[gi] = mem_q[rd_ptr_q + PTR_W'(gi)];
    end

    assign head_cnt_o = (occ_q >= OW'(LANES)) ? NW'(LANES) : NW'(occ_q);
    assign pop_cnt    = pop_i ? head_cnt_o : '0;

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt_i);
        occ_d    = occ_q + OW'(push_cnt_i) - OW'(pop_cnt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign occ_o = occ_q;

endmodule

// File: rtl/preg_release_unit.sv
// -----------------------------------------------------------------------------
// preg_release_unit
// Commit-side counterpart of the rename free list. Retiring groups update the
// architectural RAT; every overwritten physical register is queued and later
// returned to the free list. Also keeps the architectural head/tail/count
// snapshot the free list restores on flush.
// Optional feature: define PREG_RELEASE_RAT_OUT_EN to expose the registered
// arch RAT on arch_rat_o.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   flush_i          pipeline flush (blocks commit and delivery this cycle)
//   commit_*_i       retiring lanes (valid contiguous from lane 0)
//   commit_ready_o   group accepted when commit_valid_i[0] & commit_ready_o
//   free_valid_o     release lanes, contiguous from lane 0
//   free_ready_i     free list takes every presented lane
//   free_preg_o      released pregs, 0 on invalid lanes
//   arch_head_o      committed allocation pointer
//   arch_tail_o      delivered release pointer
//   arch_cnt_o       architectural free count
//   arch_rat_o       (PREG_RELEASE_RAT_OUT_EN only) registered arch RAT
// -----------------------------------------------------------------------------
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

module preg_release_unit
    import preg_release_unit_pkg::*;
#(
    parameter int PHY_REG_NUM  = PHY_REG_NUM_DEF,
    parameter int ARCH_REG_NUM = ARCH_REG_NUM_DEF,
    parameter int COMMIT_W     = `COMMIT_WIDTH,
    parameter int RB_DEPTH     = 8
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush_i,
    input  logic [COMMIT_W-1:0]                     commit_valid_i,
    output logic                                    commit_ready_o,
    input  logic [COMMIT_W-1:0]                     commit_we_i,
    input  logic [COMMIT_W-1:0][$clog2(ARCH_REG_NUM)-1:0] commit_areg_i,
    input  logic [COMMIT_W-1:0][$clog2(PHY_REG_NUM)-1:0]  commit_preg_i,
    output logic [COMMIT_W-1:0]                     free_valid_o,
    input  logic                                    free_ready_i,
    output logic [COMMIT_W-1:0][$clog2(PHY_REG_NUM)-1:0]  free_preg_o,
    output logic [$clog2(PHY_REG_NUM)-1:0]          arch_head_o,
    output logic [$clog2(PHY_REG_NUM)-1:0]          arch_tail_o,
    output logic [$clog2(PHY_REG_NUM+1)-1:0]        arch_cnt_o
`ifdef PREG_RELEASE_RAT_OUT_EN
    ,
    output logic [ARCH_REG_NUM-1:0][$clog2(PHY_REG_NUM):0] arch_rat_o
`endif
);

    localparam int PW = $clog2(PHY_REG_NUM);
    localparam int CW = $clog2(PHY_REG_NUM+1);
    localparam int NW = $clog2(COMMIT_W+1);
    localparam int OW = $clog2(RB_DEPTH+1);

    rat_entry_t rat_q [ARCH_REG_NUM];
    rat_entry_t rat_d [ARCH_REG_NUM];
    rat_entry_t old_map [COMMIT_W];

    logic [COMMIT_W-1:0]          eff;
    logic [COMMIT_W-1:0]          rel;
    logic                         accept;
    logic [NW-1:0]                alloc_cnt;
    logic [NW-1:0]                push_cnt;
    logic [COMMIT_W-1:0][PW-1:0]  push_data;
    logic [COMMIT_W-1:0][PW-1:0]  head_data;
    logic [NW-1:0]                head_cnt;
    logic [OW-1:0]                occ;
    logic                         pop;
    logic [NW-1:0]                deliv_cnt;

    logic [PW-1:0] head_q, tail_q;
    logic [CW-1:0] cnt_q;

    // ---------------------------------------------------------------- commit
    assign commit_ready_o = ((OW'(RB_DEPTH) - occ) >= OW'(COMMIT_W)) & ~flush_i;
    assign accept         = commit_valid_i[0] & commit_ready_o;

    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_commit
        // r0 is never renamed, so it neither allocates nor releases.
        assign eff[gi] = commit_valid_i[gi] & commit_we_i[gi] & (commit_areg_i[gi] != '0);

        // Old mapping: newest older lane in the group writing the same areg,
        // otherwise the committed RAT entry. Ascending scan lets the newest win.
        always_comb begin
            old_map[gi] = rat_q[commit_areg_i[gi]];
            for (int i = 0; i < gi; i++) begin
                if (eff[i] && (commit_areg_i[i] == commit_areg_i[gi])) begin
                    old_map[gi].valid = 1'b1;
                    old_map[gi].preg  = commit_preg_i[i];
                end
            end
        end

        assign rel[gi] = eff[gi] & old_map[gi].valid;
    end

    assign alloc_cnt = accept ? NW'($countones(eff)) : '0;

    // Compact releases in lane order.
    always_comb begin
        push_data = '0;
        push_cnt  = '0;
        for (int j = 0; j < COMMIT_W; j++) begin
            if (rel[j]) begin
                push_data[push_cnt] = old_map[j].preg;
                push_cnt            = push_cnt + NW'(1);
            end
        end
        if (!accept) begin
            push_cnt = '0;
        end
    end

    // Later lanes overwrite earlier ones for the same areg.
    always_comb begin
        rat_d = rat_q;
        if (accept) begin
            for (int i = 0; i < COMMIT_W; i++) begin
                if (eff[i]) begin
                    rat_d[commit_areg_i[i]].valid = 1'b1;
                    rat_d[commit_areg_i[i]].preg  = commit_preg_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int a = 0; a < ARCH_REG_NUM; a++) begin
                rat_q[a] <= '0;
            end
        end else begin
            rat_q <= rat_d;
        end
    end

    // ---------------------------------------------------------------- release
    release_fifo #(
        .DEPTH (RB_DEPTH),
        .LANES (COMMIT_W),
        .DW    (PW)
    ) u_release_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_data_i (push_data),
        .push_cnt_i  (push_cnt),
        .pop_i       (pop),
        .head_data_o (head_data),
        .head_cnt_o  (head_cnt),
        .occ_o       (occ)
    );

    // Delivery is suppressed during flush so it never coincides with the free
    // list restoring its pointers from arch_head/tail/cnt.
    assign pop       = free_ready_i & ~flush_i & (head_cnt != '0);
    assign deliv_cnt = pop ? head_cnt : '0;

    for (genvar gi = 0; gi < COMMIT_W; gi++) begin : g_free
        assign free_valid_o[gi] = ~flush_i & (NW'(gi) < head_cnt);
        assign free_preg_o[gi]  = free_valid_o[gi] ? head_data[gi] : '0;
    end

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= CW'(PHY_REG_NUM);
        end else begin
            head_q <= head_q + PW'(alloc_cnt);
            tail_q <= tail_q + PW'(deliv_cnt);
            cnt_q  <= cnt_q + CW'(deliv_cnt) - CW'(alloc_cnt);
        end
    end

    assign arch_head_o = head_q;
    assign arch_tail_o = tail_q;
    assign arch_cnt_o  = cnt_q;

`ifdef PREG_RELEASE_RAT_OUT_EN
    for (genvar gi = 0; gi < ARCH_REG_NUM; gi++) begin : g_rat_out
        assign arch_rat_o[gi] = rat_q[gi];
    end
`endif

endmodule

// File: tb/tb_preg_release_unit.sv
`timescale 1ns/1ps
`ifndef COMMIT_WIDTH
`define COMMIT_WIDTH 4
`endif

module tb_preg_release_unit;

    localparam int W    = `COMMIT_WIDTH;
    localparam int PHY  = 64;
    localparam int ARCH = 32;
    localparam int RB   = 8;
    localparam int PW   = 6;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush_i = 1'b0;
    logic [W-1:0] commit_valid_i = '0;
    logic [W-1:0] commit_we_i = '0;
    logic [W-1:0][AW-1:0] commit_areg_i = '0;
    logic [W-1:0][PW-1:0] commit_preg_i = '0;
    logic free_ready_i = 1'b0;
    logic commit_ready_o;
    logic [W-1:0] free_valid_o;
    logic [W-1:0][PW-1:0] free_preg_o;
    logic [PW-1:0] arch_head_o, arch_tail_o;
    logic [PW:0] arch_cnt_o;
`ifdef PREG_RELEASE_RAT_OUT_EN
    logic [ARCH-1:0][PW:0] arch_rat_o;
`endif

    preg_release_unit #(
        .PHY_REG_NUM (PHY), .ARCH_REG_NUM (ARCH), .COMMIT_W (W), .RB_DEPTH (RB)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush_i        (flush_i),
        .commit_valid_i (commit_valid_i),
        .commit_ready_o (commit_ready_o),
        .commit_we_i    (commit_we_i),
        .commit_areg_i  (commit_areg_i),
        .commit_preg_i  (commit_preg_i),
        .free_valid_o   (free_valid_o),
        .free_ready_i   (free_ready_i),
        .free_preg_o    (free_preg_o),
        .arch_head_o    (arch_head_o),
        .arch_tail_o    (arch_tail_o),
        .arch_cnt_o     (arch_cnt_o)
`ifdef PREG_RELEASE_RAT_OUT_EN
        ,
        .arch_rat_o     (arch_rat_o)
`endif
    );

    always #5 clk = ~clk;

    // ---------------- reference model state (driver-owned unless noted)
    int  exp_q[$];          // every release ever committed, in order
    int  rd_idx = 0;        // monitor-owned: releases already delivered
    int  pend_rel[$];
    int  pend_alloc = 0;
    bit  pend_acc = 0;
    bit  rat_v [ARCH];
    int  rat_p [ARCH];
    bit  pend_v [ARCH];
    int  pend_p [ARCH];
    int  alloc_total = 0;
    int  deliv_total = 0;   // monitor-owned
    int  n_checks = 0;
    int  n_errors = 0;
    bit  done = 0;
    bit  mon_done = 0;
    int  step_no = 0;

    // stimulus staging
    logic [W-1:0] s_valid, s_we;
    int  s_areg [W];
    int  s_preg [W];
    logic s_flush, s_ready;

    task automatic clear_lanes();
        s_valid = '0;
        s_we = '0;
        for (int i = 0; i < W; i++) begin
            s_areg[i] = 0;
            s_preg[i] = 0;
        end
    endtask

    task automatic set_lane(input int i, input bit we, input int a, input int p);
        s_valid[i] = 1'b1;
        s_we[i] = we;
        s_areg[i] = a;
        s_preg[i] = p;
    endtask

    // One clock: retire last cycle's accepted group into the model, then drive
    // the staged inputs and decide (from the model alone) whether they are taken.
    task automatic step();
        int occ;
        bit rdy;
        @(posedge clk);
        if (pend_acc) begin
            foreach (pend_rel[k]) exp_q.push_back(pend_rel[k]);
            alloc_total += pend_alloc;
            rat_v = pend_v;
            rat_p = pend_p;
        end
        pend_acc = 0;
        pend_rel.delete();
        pend_alloc = 0;
        #1;
        commit_valid_i = s_valid;
        commit_we_i = s_we;
        for (int i = 0; i < W; i++) begin
            commit_areg_i[i] = AW'(s_areg[i]);
            commit_preg_i[i] = PW'(s_preg[i]);
        end
        flush_i = s_flush;
        free_ready_i = s_ready;
        step_no++;
        occ = exp_q.size() - rd_idx;
        rdy = ((RB - occ) >= W) && !s_flush;
        if (s_valid[0] && rdy) begin
            pend_acc = 1;
            pend_v = rat_v;
            pend_p = rat_p;
            for (int i = 0; i < W; i++) begin
                if (s_valid[i] && s_we[i] && s_areg[i] != 0) begin
                    pend_alloc++;
                    if (pend_v[s_areg[i]]) pend_rel.push_back(pend_p[s_areg[i]]);
                    pend_v[s_areg[i]] = 1;
                    pend_p[s_areg[i]] = s_preg[i];
                end
            end
            $display("step %0d: group accepted valid=%b we=%b alloc=%0d releases=%0d occ=%0d",
                     step_no, s_valid, s_we, pend_alloc, pend_rel.size(), occ);
        end else begin
            $display("step %0d: no group (valid=%b flush=%0d occ=%0d) free_ready=%0d",
                     step_no, s_valid, s_flush, occ, s_ready);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard
    initial begin
        int occ, npres;
        wait (!rst);
        while (!mon_done) begin
            @(negedge clk);
            occ = exp_q.size() - rd_idx;
            chk("arch_head", int'(arch_head_o), alloc_total % PHY);
            chk("arch_tail", int'(arch_tail_o), deliv_total % PHY);
            chk("arch_cnt", int'(arch_cnt_o), PHY + deliv_total - alloc_total);
            chk("commit_ready", int'(commit_ready_o), int'(((RB - occ) >= W) && !flush_i));
            npres = flush_i ? 0 : ((occ < W) ? occ : W);
            for (int k = 0; k < W; k++) begin
                chk($sformatf("free_valid[%0d]", k), int'(free_valid_o[k]), int'(k < npres));
                chk($sformatf("free_preg[%0d]", k), int'(free_preg_o[k]),
                    (k < npres) ? exp_q[rd_idx + k] : 0);
            end
`ifdef PREG_RELEASE_RAT_OUT_EN
            for (int a = 0; a < ARCH; a++) begin
                chk($sformatf("arch_rat[%0d]", a), int'(arch_rat_o[a]),
                    (int'(rat_v[a]) << PW) | (rat_v[a] ? rat_p[a] : 0));
            end
`endif
            if (free_ready_i && npres > 0) begin
                rd_idx += npres;
                deliv_total += npres;
            end
            if (done) begin
                chk("drained_occupancy", occ, 0);
                mon_done = 1;
            end
        end
    end

    // ---------------- stimulus
    initial begin
        clear_lanes();
        s_flush = 0;
        s_ready = 1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        step();                                   // idle after reset
        clear_lanes(); set_lane(0, 1, 3, 40); step();
        clear_lanes(); step();

        // Same areg twice in one group, over an existing mapping.
        clear_lanes(); set_lane(0, 1, 5, 10); step();
        clear_lanes(); set_lane(0, 1, 5, 20); set_lane(1, 1, 5, 21); step();
        clear_lanes(); step(); step();

        // Back-pressure: 4 releases per cycle with the free list stalled.
        clear_lanes();
        for (int i = 0; i < W; i++) set_lane(i, 1, 8 + i, 30 + i);
        step();
        s_ready = 0;
        for (int r = 0; r < 4; r++) begin
            clear_lanes();
            for (int i = 0; i < W; i++) set_lane(i, 1, 8 + i, 44 + 4 * (r % 2) + i);
            step();
        end
        clear_lanes(); s_ready = 1; step(); step(); step(); step();

        // Flush with three queued releases.
        s_ready = 0;
        clear_lanes();
        for (int i = 0; i < 3; i++) set_lane(i, 1, 8 + i, 1 + i);
        step();
        clear_lanes(); step();
        s_flush = 1; s_ready = 1; set_lane(0, 1, 9, 60); step();
        s_flush = 0; clear_lanes(); step(); step();

        // Lanes that must not allocate or release.
        clear_lanes();
        set_lane(0, 1, 0, 50);
        set_lane(1, 0, 3, 51);
        set_lane(2, 1, 12, 52);
        set_lane(3, 1, 3, 53);
        step();
        clear_lanes(); set_lane(0, 0, 3, 54); set_lane(1, 1, 0, 55); step();
        clear_lanes(); step();

        // Randomized traffic (head/tail wrap many times).
        for (int n = 0; n < 400; n++) begin
            int nval;
            clear_lanes();
            nval = $urandom_range(0, W);
            for (int i = 0; i < nval; i++) begin
                set_lane(i, ($urandom_range(0, 7) != 0),
                         ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7),
                         $urandom_range(1, PHY - 1));
            end
            s_flush = ($urandom_range(0, 9) == 0);
            s_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        // Drain.
        clear_lanes(); s_flush = 0; s_ready = 1;
        repeat (10) step();
        done = 1;
        repeat (5) @(posedge clk);
        if (!mon_done) begin
            $display("FAIL monitor_timeout: got 0, expected 1");
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks,
                 mon_done ? n_errors : n_errors + 1);
        $finish;
    end

endmodule
